// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct3 constants, ALU op and immediate
// selector enums, the raw decode bundle and the per-instruction decode helpers.
package decode_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_OR     = 3'd2,
    ALU_AND    = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4
  } imm_sel_e;

  typedef struct packed {
    logic     mem_read;
    logic     mem_write;
    logic     reg_write;
    logic     out_ctr;
    logic     alu_in_ctr;
    logic     branch;
    alu_op_e  alu;
    imm_sel_e imm_sel;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic     illegal;
  } dec_bundle_t;

  // OP and OP-IMM share the funct3 -> ALU mapping; SUB exists only for OP.
  function automatic dec_bundle_t decode_ctrl(input logic [31:0] inst);
    dec_bundle_t b;
    b         = '0;
    b.alu     = ALU_ADD;
    b.imm_sel = IMM_NONE;
    b.rs1     = inst[19:15];
    b.rs2     = inst[24:20];
    b.rd      = inst[11:7];
    case (inst[6:0])
      OPC_LOAD: begin
        b.alu_in_ctr = 1'b1;
        b.out_ctr    = 1'b1;
        b.mem_read   = 1'b1;
        b.reg_write  = 1'b1;
        b.imm_sel    = IMM_I;
      end
      OPC_OPIMM, OPC_OP: begin
        b.reg_write  = 1'b1;
        b.alu_in_ctr = (inst[6:0] == OPC_OPIMM);
        b.imm_sel    = (inst[6:0] == OPC_OPIMM) ? IMM_I : IMM_NONE;
        case (inst[14:12])
          F3_ADD:  b.alu = (inst[6:0] == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
          F3_XOR:  b.alu = ALU_XOR;
          F3_OR:   b.alu = ALU_OR;
          F3_AND:  b.alu = ALU_AND;
          default: b.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        b.alu_in_ctr = 1'b1;
        b.mem_write  = 1'b1;
        b.imm_sel    = IMM_S;
      end
      OPC_BRANCH: begin
        b.alu     = ALU_SUB;
        b.branch  = 1'b1;
        b.imm_sel = IMM_B;
      end
      OPC_LUI: begin
        b.alu        = ALU_PASS_B;
        b.alu_in_ctr = 1'b1;
        b.reg_write  = 1'b1;
        b.imm_sel    = IMM_U;
      end
      default: b.illegal = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] inst, input imm_sel_e sel);
    case (sel)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/decode_ibuf.sv
// Circular instruction buffer for the decode stage; flush empties it in one cycle.
// Depth need not be a power of two, so pointers wrap explicitly.
module decode_ibuf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_pipe.sv
// Buffered RV32 decode stage: ibuf -> decode of head -> registered bundle to execute.
// Define DECODE_ILLEGAL_TRAP_EN to stall on an illegal instruction until flush.
module decode_pipe
  import decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IBUF_DEPTH = 2,
  parameter int ALU_CTR_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 reg_write,
  output logic                 out_ctr,
  output logic                 alu_in_ctr,
  output logic                 branch,
  output logic [ALU_CTR_W-1:0] alu_ctr,
  output logic [XLEN-1:0]      ext_out,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic                 illegal
);

  localparam int EW = XLEN + 32;
  localparam int CW = $clog2(IBUF_DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [XLEN-1:0]      pc;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 out_ctr;
    logic                 alu_in_ctr;
    logic                 branch;
    logic [ALU_CTR_W-1:0] alu;
    logic [XLEN-1:0]      imm;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                 illegal;
`endif
  } out_t;

  logic            push, pop, full, run;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;
  dec_bundle_t     dec;
  out_t            o, load;

  decode_ibuf #(.DEPTH(IBUF_DEPTH), .W(EW)) u_ibuf (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   ({in_pc, in_inst}),
    .dout  (head),
    .full  (full),
    .count (count)
  );

  assign {head_pc, head_inst} = head;
  assign dec = decode_ctrl(head_inst);

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_TRAP = 1'b1;
  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (!reset || flush)        state <= ST_RUN;
    else if (pop && dec.illegal) state <= ST_TRAP;
  end

  assign run = (state == ST_RUN);
`else
  assign run = 1'b1;
`endif

  assign in_ready = reset & ~full & ~flush & run;
  assign push     = in_valid & in_ready;
  assign pop      = reset & (count != '0) & (~o.valid | out_ready) & ~flush & run;

  // An illegal head becomes either a trap marker or a NOP that keeps its pc.
  always_comb begin
    load       = '0;
    load.valid = 1'b1;
    if (!dec.illegal) begin
      load.pc         = head_pc;
      load.mem_read   = dec.mem_read;
      load.mem_write  = dec.mem_write;
      load.reg_write  = dec.reg_write;
      load.out_ctr    = dec.out_ctr;
      load.alu_in_ctr = dec.alu_in_ctr;
      load.branch     = dec.branch;
      load.alu        = ALU_CTR_W'(dec.alu);
      load.imm        = XLEN'($signed(imm_gen(head_inst, dec.imm_sel)));
      load.rs1        = dec.rs1;
      load.rs2        = dec.rs2;
      load.rd         = dec.rd;
    end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      load.illegal = 1'b1;
`else
      load.pc      = head_pc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush)           o <= '0;
    else if (pop)                  o <= load;
    else if (o.valid && out_ready) o <= '0;
  end

  assign out_valid  = o.valid;
  assign out_pc     = o.pc;
  assign mem_read   = o.mem_read;
  assign mem_write  = o.mem_write;
  assign reg_write  = o.reg_write;
  assign out_ctr    = o.out_ctr;
  assign alu_in_ctr = o.alu_in_ctr;
  assign branch     = o.branch;
  assign alu_ctr    = o.alu;
  assign ext_out    = o.imm;
  assign rs1        = o.rs1;
  assign rs2        = o.rs2;
  assign rd         = o.rd;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal    = o.illegal;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// Directed + random bench for decode_pipe against a queue-level reference model.
module tb_decode_pipe;
  import decode_pkg::*;

  localparam int D = 2;
`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_inst, in_pc;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, ext_out;
  logic        mem_read, mem_write, reg_write, out_ctr, alu_in_ctr, branch, illegal;
  logic [2:0]  alu_ctr;
  logic [4:0]  rs1, rs2, rd;

  always #5 clk = ~clk;

  decode_pipe #(.XLEN(32), .IBUF_DEPTH(D), .ALU_CTR_W(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .out_ctr(out_ctr), .alu_in_ctr(alu_in_ctr), .branch(branch),
    .alu_ctr(alu_ctr), .ext_out(ext_out), .rs1(rs1), .rs2(rs2), .rd(rd),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic mr, mw, rw, oc, aic, br;
    logic [2:0]  alu;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } bun_t;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  ent_t bufq[$];
  ent_t oent;
  bit   ov, trap, last_push;
  int   checks = 0, failures = 0, step = 0;

  function automatic bit is_illegal(input logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    case (i[6:0])
      7'h03, 7'h23, 7'h63, 7'h37: return 1'b0;
      7'h13, 7'h33: return !(f3 == 3'd0 || f3 == 3'd4 || f3 == 3'd6 || f3 == 3'd7);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'd4:    return ALU_XOR;
      3'd6:    return ALU_OR;
      3'd7:    return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // Immediates as signed integers of their natural width, then widened.
  function automatic bun_t ref_bundle(input ent_t e);
    bun_t b = '0;
    logic [31:0] i = e.inst;
    int v;
    if (is_illegal(i)) begin
      if (TRAP_EN) b.ill = 1'b1;
      else         b.pc  = e.pc;
      return b;
    end
    b.pc = e.pc; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.rd = i[11:7];
    v = i[31:20];
    if (v >= 2048) v -= 4096;
    case (i[6:0])
      7'h03: begin b.alu = ALU_ADD; b.aic = 1; b.oc = 1; b.mr = 1; b.rw = 1; b.imm = 32'(v); end
      7'h13: begin b.alu = f3_alu(i[14:12]); b.aic = 1; b.rw = 1; b.imm = 32'(v); end
      7'h33: begin
        b.rw  = 1;
        b.alu = (i[14:12] == 3'd0 && i[30]) ? ALU_SUB : f3_alu(i[14:12]);
      end
      7'h23: begin
        v = {i[31:25], i[11:7]};
        if (v >= 2048) v -= 4096;
        b.alu = ALU_ADD; b.aic = 1; b.mw = 1; b.imm = 32'(v);
      end
      7'h63: begin
        v = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (v >= 4096) v -= 8192;
        b.alu = ALU_SUB; b.br = 1; b.imm = 32'(v);
      end
      default: begin b.alu = ALU_PASS_B; b.aic = 1; b.rw = 1; b.imm = i & 32'hFFFF_F000; end
    endcase
    return b;
  endfunction

  function automatic bit exp_in_ready();
    return reset && bufq.size() < D && !flush && !trap;
  endfunction

  task automatic chk(input string tag, input logic [127:0] a, input logic [127:0] e);
    checks++;
    assert (a === e) else begin
      failures++;
      $error("FAIL %s step=%0d got=%0h exp=%0h", tag, step, a, e);
    end
  endtask

  task automatic check_outputs();
    bun_t act, e;
    act = {out_pc, mem_read, mem_write, reg_write, out_ctr, alu_in_ctr, branch,
           alu_ctr, ext_out, rs1, rs2, rd, illegal};
    e = ov ? ref_bundle(oent) : bun_t'('0);
    chk("out_valid", 128'(out_valid), 128'(ov));
    chk("in_ready", 128'(in_ready), 128'(exp_in_ready()));
    chk("bundle", 128'(act), 128'(e));
  endtask

  task automatic tick();
    bit ir, pop;
    ent_t ne;
    @(negedge clk);
    check_outputs();
    ir = exp_in_ready();
    @(posedge clk);
    last_push = 1'b0;
    if (!reset || flush) begin
      bufq.delete(); ov = 0; trap = 0;
    end else begin
      pop = bufq.size() > 0 && (!ov || out_ready) && !trap;
      if (pop) begin
        oent = bufq.pop_front();
        ov   = 1;
        if (TRAP_EN && is_illegal(oent.inst)) trap = 1;
      end else if (ov && out_ready) ov = 0;
      if (in_valid && ir) begin
        ne.pc = in_pc; ne.inst = in_inst;
        bufq.push_back(ne);
        last_push = 1'b1;
      end
    end
    step++;
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h33;
      3: w[6:0] = 7'h23;
      4: w[6:0] = 7'h63;
      5: w[6:0] = 7'h37;
      default: ;
    endcase
    if (w[6:0] == 7'h13 || w[6:0] == 7'h33)
      case ($urandom_range(0, 4))
        0: w[14:12] = 3'd0;
        1: w[14:12] = 3'd4;
        2: w[14:12] = 3'd6;
        3: w[14:12] = 3'd7;
        default: ;
      endcase
    return w;
  endfunction

  initial begin
    int idx;
    logic [31:0] seq [4];
    reset = 1'b0;
    drive(1, 32'h0050_0093, 32'h0, 0, 0);
    @(posedge clk); #1;
    tick(); tick();
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    reset = 1'b1;

    // addi x1,x0,5
    drive(1, 32'h0050_0093, 32'h100, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 0); tick();
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_alu", 128'(alu_ctr), 128'(ALU_ADD));
    chk("addi_ext", 128'(ext_out), 128'(32'h5));
    chk("addi_rd", 128'(rd), 128'(1));
    chk("addi_pc", 128'(out_pc), 128'(32'h100));
    tick();

    // beq with negative offset
    drive(1, 32'hFE00_0EE3, 32'h104, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 0); tick();
    chk("beq_branch", 128'(branch), 128'(1));
    chk("beq_alu", 128'(alu_ctr), 128'(ALU_SUB));
    chk("beq_ext", 128'(ext_out), 128'(32'hFFFF_FFFC));
    tick();

    // back-pressure: fill, hold, release
    for (int k = 0; k < 4; k++) seq[k] = rand_inst() & 32'hFFFF_FF80 | 32'h13;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(idx < 4, seq[idx % 4], 32'h200 + 32'(idx * 4), 0, 0);
      tick();
      if (last_push) idx++;
    end
    chk("bp_full", 128'(in_ready), 128'(0));
    drive(0, 32'h0, 32'h0, 1, 0);
    repeat (6) tick();

    // flush with full buffer and valid output
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, 32'h0000_0037 | 32'(c << 7), 32'h400 + 32'(c * 4), 0, 0);
      tick();
    end
    drive(1, 32'h0050_0093, 32'h500, 0, 1); tick();
    drive(0, 32'h0, 32'h0, 1, 0); tick();
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    repeat (3) tick();

    // illegal instruction followed by a legal one
    drive(1, 32'hFFFF_FFFF, 32'h300, 0, 0); tick();
    drive(1, 32'h00A0_0113, 32'h304, 0, 0); tick();
    drive(0, 32'h0, 32'h0, 0, 0); repeat (3) tick();
    drive(0, 32'h0, 32'h0, 1, 0); repeat (3) tick();
    drive(0, 32'h0, 32'h0, 1, 1); tick();
    drive(1, 32'h00A0_0113, 32'h308, 1, 0); tick();
    drive(0, 32'h0, 32'h0, 1, 0); repeat (3) tick();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
